// File: rtl/ysyx22041405_pkg.sv
// Shared definitions for the ysyx22041405 instruction fetch unit.
package ysyx22041405_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrop,
    StHold
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h8000_0000;
  localparam int unsigned InstBytes      = 4;

endpackage

// File: rtl/ysyx22041405_ifu_pcgen.sv
// Architectural PC register with next-pc selection (hold / +4 / redirect) and misalign flag.
module ysyx22041405_ifu_pcgen
  import ysyx22041405_pkg::*;
#(
  parameter int unsigned       Width   = 32,
  parameter logic [Width-1:0]  ResetPc = Width'(DefaultResetPc)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_pc_i,
  input  logic             advance_i,
  output logic [Width-1:0] pc_o,
  output logic             misaligned_o
);

  logic [Width-1:0] pc_d, pc_q;

  // Redirect wins over sequential advance; +4 wraps silently at 2^Width.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + Width'(InstBytes);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = pc_q[1:0] != 2'b00;

endmodule

// File: rtl/ysyx22041405_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry buffer towards decode.
module ysyx22041405_ifu
  import ysyx22041405_pkg::*;
#(
  parameter int unsigned       Width   = 32,
  parameter logic [Width-1:0]  ResetPc = Width'(DefaultResetPc)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             imem_req_valid_o,
  input  logic             imem_req_ready_i,
  output logic [Width-1:0] imem_addr_o,
  input  logic             imem_resp_valid_i,
  input  logic [Width-1:0] imem_rdata_i,
  input  logic             imem_resp_err_i,
  input  logic             redirect_valid_i,
  input  logic [Width-1:0] redirect_pc_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [Width-1:0] inst_o,
  output logic [Width-1:0] inst_pc_o,
  output logic             inst_fault_o
);

  fetch_state_e     state_d, state_q;
  logic [Width-1:0] inst_d, inst_q;
  logic [Width-1:0] inst_pc_d, inst_pc_q;
  logic             fault_d, fault_q;

  logic [Width-1:0] pc;
  logic             misaligned;
  logic             pc_load;
  logic             pc_advance;

  ysyx22041405_ifu_pcgen #(
    .Width   (Width),
    .ResetPc (ResetPc)
  ) u_pcgen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (pc_load),
    .load_pc_i    (redirect_pc_i),
    .advance_i    (pc_advance),
    .pc_o         (pc),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d          = state_q;
    inst_d           = inst_q;
    inst_pc_d        = inst_pc_q;
    fault_d          = fault_q;
    pc_load          = 1'b0;
    pc_advance       = 1'b0;
    imem_req_valid_o = 1'b0;
    inst_valid_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        imem_req_valid_o = !redirect_valid_i && !misaligned;
        if (redirect_valid_i) begin
          pc_load = 1'b1;
        end else if (misaligned) begin
          // Misaligned PC never reaches memory; hand decode a faulting bubble instead.
          inst_d    = '0;
          inst_pc_d = pc;
          fault_d   = 1'b1;
          state_d   = StHold;
        end else if (imem_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid_i) begin
          if (redirect_valid_i) begin
            pc_load = 1'b1;
            state_d = StReq;
          end else begin
            inst_d    = imem_rdata_i;
            inst_pc_d = pc;
            fault_d   = imem_resp_err_i;
            state_d   = StHold;
          end
        end else if (redirect_valid_i) begin
          pc_load = 1'b1;
          state_d = StDrop;
        end
      end
      StDrop: begin
        // Orphan response must drain before a new request keeps the single-outstanding rule.
        pc_load = redirect_valid_i;
        if (imem_resp_valid_i) begin
          state_d = StReq;
        end
      end
      StHold: begin
        inst_valid_o = 1'b1;
        if (redirect_valid_i) begin
          pc_load = 1'b1;
          state_d = StReq;
        end else if (inst_ready_i) begin
          pc_advance = 1'b1;
          state_d    = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_addr_o  = pc;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_fault_o = fault_q;

endmodule

// File: doc/ysyx22041405_ifu.md
# ysyx22041405_ifu

Instruction fetch unit, directly upstream of the decode stage. It owns the architectural PC and issues one word fetch at a time to instruction memory over a valid/ready request channel. It buffers the returned instruction and presents it, with its PC, to decode on a valid/ready channel. Redirects from execute (branch/jump target) squash any in-flight or held instruction and restart fetch at the new PC.

## Interface
- WIDTH, 32, datapath/address width
- RESET_PC, 32'h8000_0000, first fetch address after reset
---
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  WIDTH  fetch address (= current PC)
- imem_resp_valid  in  1  response word valid
- imem_rdata  in  WIDTH  fetched word
- imem_resp_err  in  1  access fault for this response
- redirect_valid  in  1  execute redirect, single-cycle pulse or held
- redirect_pc  in  WIDTH  redirect target
- inst_valid  out  1  instruction held for decode
- inst_ready  in  1  decode consumes this cycle
- inst  out  WIDTH  instruction word to decode
- inst_pc  out  WIDTH  PC of `inst`
- inst_fault  out  1  instruction carries fetch fault (access or misaligned)

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. Reset: state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_fault=0; all outputs 0 (imem_addr=pc).
- IDLE: next state REQ unconditionally (first cycle after reset release).
- REQ: imem_req_valid = !redirect_valid && pc[1:0]==0; imem_addr=pc.
  - redirect_valid: pc<=redirect_pc, stay REQ; no handshake that cycle.
  - pc[1:0]!=0: no request; inst<=0, inst_pc<=pc, inst_fault<=1, go HOLD.
  - imem_req_ready: go WAIT.
- WAIT: imem_resp_valid sampled only here and in DROP.
  - resp && !redirect: inst<=imem_rdata, inst_pc<=pc, inst_fault<=imem_resp_err, go HOLD.
  - resp && redirect: discard word, pc<=redirect_pc, go REQ.
  - !resp && redirect: pc<=redirect_pc, go DROP.
- DROP: wait for the orphan response; on imem_resp_valid discard it and go REQ. Redirect in DROP updates pc, stays DROP.
- HOLD: inst_valid=1; inst/inst_pc/inst_fault stable until leaving HOLD.
  - redirect_valid (priority over inst_ready): inst_valid low next cycle, pc<=redirect_pc, go REQ; held instruction squashed even if inst_ready was high.
  - inst_ready: pc<=pc+4 (modulo 2^WIDTH, wraps silently), go REQ.
- At most one outstanding memory request, ever. inst_valid never asserted outside HOLD.

## Timing
- Zero-wait memory (ready in REQ, resp next cycle), decode always ready: REQ, WAIT, HOLD -> 3 cycles per instruction.
- Redirect to first new request on imem: 1 cycle (REQ in the cycle after the redirect), except from WAIT without response (DROP until orphan returns).
- inst_valid rises the cycle after the response cycle; falls the cycle after handshake or redirect.
- rst assertion mid-fetch: immediate return to IDLE; any response arriving later is ignored (state IDLE/REQ does not sample resp). Memory side must tolerate the abandoned request.
- imem_req_valid, once asserted in REQ without redirect, stays asserted with stable imem_addr until imem_req_ready.

## Structure
- Shared package ysyx22041405_pkg: fetch-state encodings (IDLE/REQ/WAIT/DROP/HOLD), RESET_PC default, INST_BYTES=4.
- One sub-module: ysyx22041405_ifu_pcgen (pc register, next-pc mux: hold / +4 / redirect_pc, misalign flag); FSM and instruction buffer stay in the top.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013, inst_ready=1 -> imem_addr 8000_0000, 8000_0004, 8000_0008 on successive REQ cycles; inst_valid every 3rd cycle with matching inst_pc.
- inst_ready low 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req_valid, then one handshake and pc+4.
- Redirect to 8000_0100 in WAIT with response 4 cycles late -> DROP, orphan word never on inst, next imem_addr 8000_0100.
- Redirect to 8000_0102 -> no imem request, inst_valid=1, inst_fault=1, inst_pc=8000_0102, inst=0.
- imem_resp_err=1 on fetch at 8000_0010 -> inst_fault=1, inst_pc=8000_0010; redirect and inst_ready same cycle in HOLD -> squash, next addr = redirect_pc.
- pc=FFFF_FFFC consumed -> next imem_addr 0000_0000; rst low during WAIT -> all outputs 0, restart at RESET_PC.
